// File: rtl/adjust_mode_sequencer.sv
// Field-select sequencer for clock time adjustment: mode button cycles the
// selected field, increment button steps it with hold-to-repeat, and the field blinks.
module adjust_mode_sequencer #(
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  parameter int TIMEOUT       = 1000,
  parameter int BLINK_HALF    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [2:0] adjust_mode,
  output logic       adjust_increment,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ADJ_H = 2'd1,
    ADJ_M = 2'd2,
    ADJ_S = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX   = 16'hFFFF;
  localparam logic [15:0] DELAY_C   = 16'(REPEAT_DELAY);
  localparam logic [15:0] PERIOD_C  = 16'(REPEAT_PERIOD);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [15:0] HALF_C    = 16'(BLINK_HALF);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  function automatic state_t advance(input state_t s);
    case (s)
      RUN:     return ADJ_H;
      ADJ_H:   return ADJ_M;
      ADJ_M:   return ADJ_S;
      ADJ_S:   return RUN;
      default: return RUN;
    endcase
  endfunction

  function automatic logic [2:0] decode(input state_t s);
    case (s)
      RUN:     return 3'b000;
      ADJ_H:   return 3'b100;
      ADJ_M:   return 3'b010;
      ADJ_S:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  state_t      state;
  state_t      state_next;
  logic        primed;
  logic        mode_prev;
  logic        inc_prev;
  logic        mode_edge;
  logic        inc_edge;
  logic        in_adj;
  logic        timeout_hit;
  logic        run_next;
  logic        rep_hit;
  logic        hold_active;
  logic        repeating;
  logic [15:0] hold_cnt;
  logic [15:0] idle_cnt;
  logic [15:0] blink_cnt;
  logic [15:0] hold_inc;
  logic [15:0] idle_inc;
  logic [15:0] blink_inc;

  // Edge detection, timeout and next-state decisions shared by all register groups
  always_comb begin
    mode_edge   = primed & btn_mode & ~mode_prev;
    inc_edge    = primed & btn_inc & ~inc_prev;
    in_adj      = (state != RUN);
    hold_inc    = sat_inc(hold_cnt);
    idle_inc    = sat_inc(idle_cnt);
    blink_inc   = sat_inc(blink_cnt);
    timeout_hit = 1'b0;
    if (in_adj && !mode_edge && !btn_inc && tick && (idle_inc >= TIMEOUT_C)) begin
      timeout_hit = 1'b1;
    end else begin
      timeout_hit = 1'b0;
    end
    if (mode_edge) begin
      state_next = advance(state);
    end else if (timeout_hit) begin
      state_next = RUN;
    end else begin
      state_next = state;
    end
    run_next = (state_next == RUN);
    // The !adjust_increment guard only defers a step, it never drops one
    rep_hit = 1'b0;
    if (in_adj && !mode_edge && !inc_edge && btn_inc && hold_active && tick && !adjust_increment) begin
      if (repeating) begin
        rep_hit = (hold_inc >= PERIOD_C);
      end else begin
        rep_hit = (hold_inc >= DELAY_C);
      end
    end else begin
      rep_hit = 1'b0;
    end
  end

  // Previous button levels; primed keeps a level held through reset from counting as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed    <= 1'b0;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      primed    <= 1'b1;
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
    end
  end

  // Field-select FSM with registered one-hot decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      adjust_mode <= 3'b000;
    end else begin
      state       <= state_next;
      adjust_mode <= decode(state_next);
    end
  end

  // Hold tracking: only a press made inside the current adjust state may auto-repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_active <= 1'b0;
      repeating   <= 1'b0;
      hold_cnt    <= 16'd0;
    end else if (run_next || mode_edge || !btn_inc) begin
      hold_active <= 1'b0;
      repeating   <= 1'b0;
      hold_cnt    <= 16'd0;
    end else if (inc_edge) begin
      hold_active <= 1'b1;
      repeating   <= 1'b0;
      hold_cnt    <= 16'd0;
    end else if (rep_hit) begin
      repeating   <= 1'b1;
      hold_cnt    <= 16'd0;
    end else if (hold_active && tick) begin
      hold_cnt    <= hold_inc;
    end else begin
      hold_cnt    <= hold_cnt;
    end
  end

  // Step pulse: one on a fresh press, then one per repeat interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adjust_increment <= 1'b0;
    end else begin
      adjust_increment <= (!run_next && !mode_edge && inc_edge) || rep_hit;
    end
  end

  // Inactivity counter; holding btn_inc counts as activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 16'd0;
    end else if (run_next || mode_edge || btn_inc) begin
      idle_cnt <= 16'd0;
    end else if (tick) begin
      idle_cnt <= idle_inc;
    end else begin
      idle_cnt <= idle_cnt;
    end
  end

  // Blink phase: restarts visible on entry and on any button press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= 1'b0;
      blink_cnt <= 16'd0;
    end else if (run_next) begin
      blink     <= 1'b0;
      blink_cnt <= 16'd0;
    end else if (mode_edge || inc_edge) begin
      blink     <= 1'b1;
      blink_cnt <= 16'd0;
    end else if (tick) begin
      if (blink_inc >= HALF_C) begin
        blink     <= ~blink;
        blink_cnt <= 16'd0;
      end else begin
        blink     <= blink;
        blink_cnt <= blink_inc;
      end
    end else begin
      blink     <= blink;
      blink_cnt <= blink_cnt;
    end
  end

endmodule
